// File: rtl/stream_mux_arb_if.sv
// stream_mux_arb_if
//   Bundle of the handshake and data signals around stream_mux_arb.
//   master : the producer/consumer side (drives in_*, out_ready).
//   slave  : the multiplexer side (drives in_ready, out_*).
// Signals
//   in_valid[N]      per-channel beat valid
//   in_data[N*WIDTH] channel i at [i*WIDTH +: WIDTH]
//   in_last[N]       final beat of a packet
//   in_ready[N]      per-channel accept (combinational in the slave)
//   out_valid        output register holds a beat
//   out_data[WIDTH]  registered data
//   out_last         registered last flag
//   out_sel[SELW]    channel the held beat came from
//   out_ready        downstream accept
interface stream_mux_arb_if #(
  parameter int N     = 2,
  parameter int WIDTH = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [SELW-1:0]    out_sel;
  logic               out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );
endinterface

// File: rtl/stream_mux_arb.sv
// stream_mux_arb
//   N-input registered stream multiplexer with a built-in arbiter.
//   MODE 0 = round-robin (pointer moves past the channel that finished a
//   packet), MODE 1 = fixed priority (lowest index wins). Once a non-last
//   beat is accepted the channel is locked until its last beat, so packets
//   are never interleaved.
// Ports
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset
//   bus   : stream_mux_arb_if.slave (in_valid/in_data/in_last/in_ready,
//           out_valid/out_data/out_last/out_sel/out_ready)
module stream_mux_arb #(
  parameter int WIDTH = 4,
  parameter int N     = 2,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  stream_mux_arb_if.slave  bus
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t      state_q, state_d;
  logic [SELW-1:0]  lock_ch_q, lock_ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;

  logic             free;
  logic             grant_valid;
  logic [SELW-1:0]  grant_idx;
  logic             accept;
  int               cand;
  logic [SELW-1:0]  cand_idx;

  logic [WIDTH-1:0] ch_data [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
      assign bus.in_ready[gi] = free & grant_valid & (grant_idx == SELW'(gi)) & ~reset;
    end
  endgenerate

  assign free = ~out_valid_q | bus.out_ready;

  // Grant selection. Loops run from the far end downwards so the
  // highest-priority candidate is the last one written.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    if (state_q == LOCKED) begin
      // Mid-packet: only the owning channel may proceed.
      grant_valid = bus.in_valid[lock_ch_q];
      grant_idx   = lock_ch_q;
    end else if (MODE == 1) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (bus.in_valid[SELW'(k)]) begin
          grant_valid = 1'b1;
          grant_idx   = SELW'(k);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        cand = int'(ptr_q) + k;
        if (cand >= N) cand = cand - N;
        cand_idx = cand[SELW-1:0];
        if (bus.in_valid[cand_idx]) begin
          grant_valid = 1'b1;
          grant_idx   = cand_idx;
        end
      end
    end
  end

  // grant_valid already implies in_valid of the granted channel.
  assign accept = grant_valid & free & ~reset;

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_last_d  = bus.in_last[grant_idx];
      out_sel_d   = grant_idx;
      if (bus.in_last[grant_idx]) begin
        state_d = UNLOCKED;
        if (MODE == 0) begin
          ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
      end else begin
        state_d   = LOCKED;
        lock_ch_d = grant_idx;
      end
    end else if (free) begin
      // Beat consumed downstream with nothing to replace it; payload kept.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb
//   Two instances (N=4, WIDTH=8): u_rr in round-robin mode, u_fp in fixed
//   priority mode. Each has its own random producers and consumer and is
//   compared every cycle against a transaction-level model of the arbiter.
module tb_stream_mux_arb;
  localparam int N = 4;
  localparam int W = 8;
  localparam int CYCLES = 3000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stream_mux_arb_if #(.N(N), .WIDTH(W)) if_rr ();
  stream_mux_arb_if #(.N(N), .WIDTH(W)) if_fp ();

  stream_mux_arb #(.WIDTH(W), .N(N), .MODE(0)) u_rr (.clk(clk), .reset(reset), .bus(if_rr));
  stream_mux_arb #(.WIDTH(W), .N(N), .MODE(1)) u_fp (.clk(clk), .reset(reset), .bus(if_fp));

  // Index 0 = round-robin instance, index 1 = fixed-priority instance.
  logic [N-1:0]   vld  [2];
  logic [N-1:0]   lst  [2];
  logic [N*W-1:0] dat  [2];
  logic           ordy [2];
  logic [N-1:0]   rdy  [2];
  logic           ov   [2];
  logic [W-1:0]   od   [2];
  logic           ol   [2];
  logic [1:0]     os   [2];

  assign if_rr.in_valid  = vld[0];
  assign if_rr.in_last   = lst[0];
  assign if_rr.in_data   = dat[0];
  assign if_rr.out_ready = ordy[0];
  assign if_fp.in_valid  = vld[1];
  assign if_fp.in_last   = lst[1];
  assign if_fp.in_data   = dat[1];
  assign if_fp.out_ready = ordy[1];
  assign rdy[0] = if_rr.in_ready;
  assign ov[0]  = if_rr.out_valid;
  assign od[0]  = if_rr.out_data;
  assign ol[0]  = if_rr.out_last;
  assign os[0]  = if_rr.out_sel;
  assign rdy[1] = if_fp.in_ready;
  assign ov[1]  = if_fp.out_valid;
  assign od[1]  = if_fp.out_data;
  assign ol[1]  = if_fp.out_last;
  assign os[1]  = if_fp.out_sel;

  // Producer state: the beat each channel is currently offering.
  bit       pend  [2][N];
  bit [7:0] pdata [2][N];
  bit       plast [2][N];

  // Reference model state.
  bit       m_lock    [2];
  int       m_lock_ch [2];
  int       m_ptr     [2];
  bit       e_ov [2];
  bit [7:0] e_od [2];
  bit       e_ol [2];
  int       e_os [2];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Which channel the arbiter should grant this cycle, or -1 for none.
  function automatic int model_grant(input int d);
    int c;
    if (m_lock[d]) return vld[d][m_lock_ch[d]] ? m_lock_ch[d] : -1;
    for (int k = 0; k < N; k++) begin
      c = (d == 0) ? (m_ptr[d] + k) % N : k;
      if (vld[d][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lock[d] = 0; m_lock_ch[d] = 0; m_ptr[d] = 0;
      e_ov[d] = 0; e_od[d] = 0; e_ol[d] = 0; e_os[d] = 0;
    end
  endtask

  initial begin
    int pv, pl, pr, g, exp_rdy, phase;
    bit rst_now, free;

    // Reset with every channel requesting: nothing may be accepted.
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = '1; lst[d] = '1; dat[d] = '0; ordy[d] = 1'b1;
      for (int i = 0; i < N; i++) begin pend[d][i] = 0; pdata[d][i] = 0; plast[d][i] = 0; end
    end
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check_eq("rdy_in_reset_rr", 32'(rdy[0]), 0);
      check_eq("rdy_in_reset_fp", 32'(rdy[1]), 0);
    end

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check_eq(d == 0 ? "out_valid_rr" : "out_valid_fp", 32'(ov[d]), 32'(e_ov[d]));
        check_eq(d == 0 ? "out_data_rr"  : "out_data_fp",  32'(od[d]), 32'(e_od[d]));
        check_eq(d == 0 ? "out_last_rr"  : "out_last_fp",  32'(ol[d]), 32'(e_ol[d]));
        check_eq(d == 0 ? "out_sel_rr"   : "out_sel_fp",   32'(os[d]), e_os[d]);
      end

      phase = cyc / 500;
      case (phase)
        0:       begin pv = 100; pl = 100; pr = 100; end
        1:       begin pv = 70;  pl = 40;  pr = 100; end
        2:       begin pv = 60;  pl = 50;  pr = 50;  end
        3:       begin pv = 30;  pl = 30;  pr = 80;  end
        4:       begin pv = 90;  pl = 20;  pr = 30;  end
        default: begin pv = 80;  pl = 35;  pr = 70;  end
      endcase
      rst_now = (cyc == 1250) || (cyc == 1251) || (cyc > 500 && $urandom_range(0, 199) == 0);
      reset = rst_now;

      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if (!pend[d][i] && $urandom_range(0, 99) < pv) begin
            pend[d][i]  = 1;
            pdata[d][i] = 8'($urandom);
            plast[d][i] = ($urandom_range(0, 99) < pl);
          end
          vld[d][i]       = pend[d][i];
          lst[d][i]       = plast[d][i];
          dat[d][i*W +: W] = pdata[d][i];
        end
        ordy[d] = ($urandom_range(0, 99) < pr);
      end

      #1;
      for (int d = 0; d < 2; d++) begin
        g = model_grant(d);
        free = !e_ov[d] || ordy[d];
        exp_rdy = (rst_now || !free || g < 0) ? 0 : (1 << g);
        check_eq(d == 0 ? "in_ready_rr" : "in_ready_fp", 32'(rdy[d]), exp_rdy);
        if (rst_now) begin
          m_lock[d] = 0; m_lock_ch[d] = 0; m_ptr[d] = 0;
          e_ov[d] = 0; e_od[d] = 0; e_ol[d] = 0; e_os[d] = 0;
        end else if (exp_rdy != 0) begin
          e_ov[d] = 1; e_od[d] = pdata[d][g]; e_ol[d] = plast[d][g]; e_os[d] = g;
          pend[d][g] = 0;
          if (plast[d][g]) begin
            m_lock[d] = 0;
            if (d == 0) m_ptr[d] = (g + 1) % N;
          end else begin
            m_lock[d] = 1;
            m_lock_ch[d] = g;
          end
          $display("beat inst=%s ch=%0d data=%02h last=%0d", d == 0 ? "rr" : "fp", g, pdata[d][g], plast[d][g]);
        end else if (free) begin
          e_ov[d] = 0;
        end
      end
    end

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq(d == 0 ? "final_valid_rr" : "final_valid_fp", 32'(ov[d]), 32'(e_ov[d]));
      check_eq(d == 0 ? "final_sel_rr"   : "final_sel_fp",   32'(os[d]), e_os[d]);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Parametrised N-input, WIDTH-bit registered stream multiplexer with valid/ready handshakes and a built-in arbiter. It replaces the static select input of the plain 2:1 mux with request-driven channel selection, using either round-robin or fixed-priority arbitration. A packet lock on `in_last` keeps multi-beat packets contiguous. It sits wherever several producers share one downstream datapath, for example bus/result merging ahead of a register stage.

## Interface
- `WIDTH`, 4: data bits per channel.
- `N`, 2: number of input channels, ≥1.
- `MODE`, 0: arbitration mode.
  - 0 = round-robin.
  - 1 = fixed priority; the lowest index wins.
- `SELW`, derived as max(1, $clog2(N)): width of the channel index.

- `clk` in 1: single clock; every register updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in N: per-channel beat valid.
- `in_data` in N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_last` in N: the beat is the final beat of its packet.
- `in_ready` out N: per-channel accept. This output is combinational.
- `out_valid` out 1: the output register holds a beat.
- `out_data` out WIDTH: registered data.
- `out_last` out 1: registered last flag.
- `out_sel` out SELW: index of the channel the held beat came from.
- `out_ready` in 1: downstream accept.

## Operation
- **Output stage.** One output register stage.
  - `free` = !out_valid | out_ready.
- **Grant, when `lock` = 1.** The grant is `lock_ch`, and only if `in_valid[lock_ch]` is high. Otherwise there is no grant; other channels are never granted mid-packet.
- **Grant, when `lock` = 0.**
  - MODE 0: the first valid channel scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - MODE 1: the lowest-index valid channel.
  - With no valid channel there is no grant.
- **Ready.** `in_ready[i]` = free & grant==i & !reset. At most one bit is set at a time.
- **Accept.** When `in_valid[g]` & `in_ready[g]`:
  - out_data ← in_data[g], out_last ← in_last[g], out_sel ← g, out_valid ← 1.
- **Drain.** When `free` is high and nothing is accepted, out_valid ← 0. out_data, out_last and out_sel keep their last values.
- **Hold.** When out_valid & !out_ready, all out_* hold stable and every in_ready is 0.
- **Lock state machine.** States UNLOCKED and LOCKED(ch).
  - UNLOCKED → LOCKED(g) on accepting a beat with in_last=0.
  - LOCKED → UNLOCKED on accepting a beat with in_last=1.
  - A single-beat packet (last=1 while UNLOCKED) stays UNLOCKED.
- **Round-robin pointer** (MODE 0 only).
  - On accepting a beat with in_last=1 from channel g, ptr ← g+1, wrapping N-1 → 0.
  - ptr does not advance on non-last beats.
  - MODE 1 never uses ptr; its value there is don't-care.
- **Single channel.** N=1 degenerates to a registered pipe stage; out_sel is constantly 0.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - lock=0, lock_ch=0, ptr=0.
  - in_ready=0 for as long as reset is high.
- Latency is 1 cycle: a beat accepted on edge k appears on out_* after edge k and is visible in cycle k+1.
- Throughput is 1 beat/cycle while out_ready=1 and a granted channel is valid. There is no bubble on a channel switch.
- out_ready feeds in_ready through a combinational path (no skid buffer). Downstream must not derive out_ready combinationally from in_ready.
- Producers must hold in_valid/in_data/in_last stable until accepted. Dropping in_valid before acceptance is a protocol violation and its result is undefined.
- Reset mid-packet discards the held beat, clears lock and returns ptr to 0. It takes effect on the edge where reset is sampled high.
- Simultaneous requests are resolved in the same cycle by the grant rule. Losers see in_ready=0 and hold.

## Test plan
- **Reset.** Assert reset for 2 cycles with all in_valid=1 → in_ready=0 throughout; after release out_valid=0, out_sel=0, out_data=0.
- **Round-robin.** N=4, WIDTH=8, MODE 0, all channels valid with single-beat packets (last=1), data=8'hA0+i, out_ready=1 → out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0.
- **Packet lock.** MODE 0, ch1 sends 3 beats (last on the 3rd) while ch0 and ch2 are valid → out_sel = 1,1,1 then 2. If ch1 idles one cycle mid-packet, out_valid=0 for one cycle and no other channel is granted.
- **Fixed priority.** MODE 1, ch0 and ch3 valid continuously with last=1 → out_sel stays 0. When ch0 deasserts, out_sel=3 on the next output beat.
- **Backpressure.** Hold out_ready=0 for 3 cycles while out_valid=1 → out_data/out_sel/out_last stable and all in_ready=0. Releasing out_ready accepts the next beat in the same cycle.
- **Pointer wrap and reset mid-packet.**
  - N=3: after the last beat from ch2, ptr=0, so ch0 wins over ch1.
  - Assert reset after a non-last beat → the lock clears, and the first post-reset grant follows ptr=0 priority.
